// File: rtl/gun_overlay_pkg.sv
// Shared types and colour constants for the light-gun cursor overlay.
package gun_overlay_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    CUR_CROSS = 2'd0,
    CUR_BOX   = 2'd1,
    CUR_LINES = 2'd2,
    CUR_DOT   = 2'd3
  } cursor_mode_e;

  localparam rgb_t GUN_COLOR [4] = '{24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFF00FF};
  localparam rgb_t TRIGGER_COLOR = 24'hFF0000;

endpackage

// File: rtl/gun_cursor_channel.sv
// One cursor channel: frame-latched gun position, clipped hit test and trigger flash state.
// GUN_CURSOR_FLASH_HOLD_EN adds a per-gun hold counter that stretches the flash over frames.
module gun_cursor_channel
  import gun_overlay_pkg::*;
#(
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned CROSS_SIZE = 4
`ifdef GUN_CURSOR_FLASH_HOLD_EN
  ,
  parameter int unsigned HOLD_FRAMES = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_ce,
  input  logic               vblank_rise,
  input  logic [1:0]         cross_mode,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] max_y,
  input  logic [COORD_W-1:0] x_pix,
  input  logic [COORD_W-1:0] y_pix,
  input  logic               blank,
  input  logic [COORD_W-1:0] gun_x,
  input  logic [COORD_W-1:0] gun_y,
  input  logic               gun_valid,
  input  logic               gun_trigger,
  output logic               hit,
  output logic               flashing
);

  localparam int unsigned EW = COORD_W + 1;
  localparam logic [EW-1:0] ARM = EW'(CROSS_SIZE);

  logic [COORD_W-1:0] gx_q, gy_q;
  logic               valid_q;

  // Position is only taken at the start of vertical blank so a cursor never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gx_q    <= '0;
      gy_q    <= '0;
      valid_q <= 1'b0;
    end else if (pixel_ce && vblank_rise) begin
      gx_q    <= gun_x;
      gy_q    <= gun_y;
      valid_q <= gun_valid;
    end
  end

  logic [EW-1:0] gx_e, gy_e, x_e, y_e, mx_e, my_e;
  logic [EW-1:0] sum_x, sum_y, lox, hix, loy, hiy;
  logic          in_x, in_y, on_screen, shape_hit;

  always_comb begin
    gx_e  = {1'b0, gx_q};
    gy_e  = {1'b0, gy_q};
    x_e   = {1'b0, x_pix};
    y_e   = {1'b0, y_pix};
    mx_e  = {1'b0, max_x};
    my_e  = {1'b0, max_y};
    sum_x = gx_e + ARM;
    sum_y = gy_e + ARM;
    lox   = (gx_e >= ARM) ? gx_e - ARM : '0;
    loy   = (gy_e >= ARM) ? gy_e - ARM : '0;
    hix   = (sum_x > mx_e) ? mx_e : sum_x;
    hiy   = (sum_y > my_e) ? my_e : sum_y;

    in_x      = (x_e >= lox) && (x_e <= hix);
    in_y      = (y_e >= loy) && (y_e <= hiy);
    on_screen = (gx_e <= mx_e) && (gy_e <= my_e);

    unique case (cursor_mode_e'(cross_mode))
      CUR_CROSS: shape_hit = ((y_e == gy_e) && in_x) || ((x_e == gx_e) && in_y);
      CUR_BOX:   shape_hit = (in_x && ((y_e == loy) || (y_e == hiy))) ||
                             (in_y && ((x_e == lox) || (x_e == hix)));
      CUR_LINES: shape_hit = (x_e == gx_e) || (y_e == gy_e);
      CUR_DOT:   shape_hit = in_x && in_y;
    endcase

    hit = shape_hit && valid_q && on_screen && !blank;
  end

`ifdef GUN_CURSOR_FLASH_HOLD_EN
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

  logic       trig_q;
  logic [7:0] hold_q;

  // A fresh trigger press reloads the counter even on a vblank edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 1'b0;
      hold_q <= '0;
    end else if (pixel_ce) begin
      trig_q <= gun_trigger;
      if (gun_trigger && !trig_q) begin
        hold_q <= HOLD_INIT;
      end else if (vblank_rise && (hold_q != 8'd0)) begin
        hold_q <= hold_q - 8'd1;
      end
    end
  end

  assign flashing = (hold_q != 8'd0) || gun_trigger;
`else
  assign flashing = gun_trigger;
`endif

endmodule

// File: rtl/gun_cursor_overlay.sv
// Multi-gun cursor overlay on the post-OSD pixel stream; two pixel_ce stages of latency.
// Define GUN_CURSOR_FLASH_HOLD_EN to keep the trigger colour for HOLD_FRAMES frames.
module gun_cursor_overlay
  import gun_overlay_pkg::*;
#(
  parameter int unsigned NUM_GUNS    = 2,
  parameter int unsigned COORD_W     = 12,
  parameter int unsigned CROSS_SIZE  = 4,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_ce,
  input  logic                        enable,
  input  logic [1:0]                  cross_mode,
  input  logic [COORD_W-1:0]          max_x,
  input  logic [COORD_W-1:0]          max_y,
  input  logic [COORD_W-1:0]          x_pix,
  input  logic [COORD_W-1:0]          y_pix,
  input  logic [7:0]                  R_in,
  input  logic [7:0]                  G_in,
  input  logic [7:0]                  B_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        hblank_in,
  input  logic                        vblank_in,
  input  logic [NUM_GUNS*COORD_W-1:0] gun_x,
  input  logic [NUM_GUNS*COORD_W-1:0] gun_y,
  input  logic [NUM_GUNS-1:0]         gun_trigger,
  input  logic [NUM_GUNS-1:0]         gun_valid,
  output logic [7:0]                  R_out,
  output logic [7:0]                  G_out,
  output logic [7:0]                  B_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblank_out,
  output logic                        vblank_out,
  output logic [NUM_GUNS-1:0]         cursor_hit
);

  if (NUM_GUNS < 1 || NUM_GUNS > 4 || HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_param_check
    $error("gun_cursor_overlay: NUM_GUNS must be 1..4 and HOLD_FRAMES 1..255");
  end

  logic vblank_prev_q;
  logic vblank_rise;

  assign vblank_rise = vblank_in && !vblank_prev_q;

  logic [NUM_GUNS-1:0] hit_c, flash_c;

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_chan
    gun_cursor_channel #(
      .COORD_W    (COORD_W),
      .CROSS_SIZE (CROSS_SIZE)
`ifdef GUN_CURSOR_FLASH_HOLD_EN
      ,
      .HOLD_FRAMES(HOLD_FRAMES)
`endif
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .pixel_ce   (pixel_ce),
      .vblank_rise(vblank_rise),
      .cross_mode (cross_mode),
      .max_x      (max_x),
      .max_y      (max_y),
      .x_pix      (x_pix),
      .y_pix      (y_pix),
      .blank      (hblank_in || vblank_in),
      .gun_x      (gun_x[g*COORD_W +: COORD_W]),
      .gun_y      (gun_y[g*COORD_W +: COORD_W]),
      .gun_valid  (gun_valid[g]),
      .gun_trigger(gun_trigger[g]),
      .hit        (hit_c[g]),
      .flashing   (flash_c[g])
    );
  end

  // Stage 1: hit tests plus the video they refer to.
  rgb_t                rgb_s1_q;
  logic [3:0]          sync_s1_q;
  logic [NUM_GUNS-1:0] hit_s1_q, flash_s1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_prev_q <= 1'b0;
      rgb_s1_q      <= '0;
      sync_s1_q     <= '0;
      hit_s1_q      <= '0;
      flash_s1_q    <= '0;
    end else if (pixel_ce) begin
      vblank_prev_q <= vblank_in;
      rgb_s1_q      <= {R_in, G_in, B_in};
      sync_s1_q     <= {hsync_in, vsync_in, hblank_in, vblank_in};
      hit_s1_q      <= hit_c & {NUM_GUNS{enable}};
      flash_s1_q    <= flash_c;
    end
  end

  // Priority chain: the lowest-index hitting gun ends up at the head.
  rgb_t color_chain [NUM_GUNS+1];

  assign color_chain[NUM_GUNS] = rgb_s1_q;

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_prio
    assign color_chain[g] = !hit_s1_q[g] ? color_chain[g+1] :
                            flash_s1_q[g] ? TRIGGER_COLOR : GUN_COLOR[g];
  end

  // Stage 2: colour mux output.
  rgb_t                rgb_out_q;
  logic [3:0]          sync_out_q;
  logic [NUM_GUNS-1:0] hit_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out_q  <= '0;
      sync_out_q <= '0;
      hit_out_q  <= '0;
    end else if (pixel_ce) begin
      rgb_out_q  <= color_chain[0];
      sync_out_q <= sync_s1_q;
      hit_out_q  <= hit_s1_q;
    end
  end

  assign R_out      = rgb_out_q[23:16];
  assign G_out      = rgb_out_q[15:8];
  assign B_out      = rgb_out_q[7:0];
  assign hsync_out  = sync_out_q[3];
  assign vsync_out  = sync_out_q[2];
  assign hblank_out = sync_out_q[1];
  assign vblank_out = sync_out_q[0];
  assign cursor_hit = hit_out_q;

endmodule
